sample_tick_generator: RTL

//  Converts the playback-rate word from the speed controller (Hz, 32-bit) into a
//  one-cycle sample strobe and a ~50% duty sample clock in the system clock domain.

---
 rtl/sample_tick_generator.sv | 83 ++++++++
 1 files changed

// File: rtl/sample_tick_generator.sv
// rtl/sample_tick_generator.sv - phase-accumulator sample strobe and square-wave generator
// Clamped rate word drives a 33-bit accumulator; rate changes land only on tick edges.
module sample_tick_generator #(
  parameter logic [31:0] CLK_FREQ     = 32'd50_000_000,
  parameter logic [31:0] MIN_FREQ     = 32'd1_000,
  parameter logic [31:0] MAX_FREQ     = 32'd48_000,
  parameter logic [31:0] DEFAULT_FREQ = 32'd22_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] freq_in,
  output logic        tick,
  output logic        out_clk,
  output logic [31:0] active_freq,
  output logic        clamped
);

  localparam logic [32:0] CLK_FREQ_W = {1'b0, CLK_FREQ};
  localparam logic [32:0] HALF_FREQ  = CLK_FREQ_W >> 1;

  logic [32:0] acc_q, acc_d;
  logic        tick_q, tick_d;
  logic        out_clk_q, out_clk_d;
  logic [31:0] active_freq_q, active_freq_d;
  logic        clamped_q, clamped_d;

  logic [31:0] f_c;
  logic [32:0] sum;
  logic        wrap;

  always_comb begin
    f_c = freq_in;
    if (freq_in < MIN_FREQ) begin
      f_c = MIN_FREQ;
    end else if (freq_in > MAX_FREQ) begin
      f_c = MAX_FREQ;
    end

    sum  = acc_q + {1'b0, active_freq_q};
    wrap = (sum >= CLK_FREQ_W);

    acc_d         = acc_q;
    tick_d        = 1'b0;
    out_clk_d     = out_clk_q;
    active_freq_d = active_freq_q;
    clamped_d     = (f_c != freq_in);

    if (enable) begin
      acc_d     = wrap ? (sum - CLK_FREQ_W) : sum;
      tick_d    = wrap;
      out_clk_d = (acc_d >= HALF_FREQ);
      // New rate only on the wrapping edge so the period in flight is never glitched.
      if (wrap) begin
        active_freq_d = f_c;
      end
    end else begin
      active_freq_d = f_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q         <= '0;
      tick_q        <= 1'b0;
      out_clk_q     <= 1'b0;
      active_freq_q <= DEFAULT_FREQ;
      clamped_q     <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      tick_q        <= tick_d;
      out_clk_q     <= out_clk_d;
      active_freq_q <= active_freq_d;
      clamped_q     <= clamped_d;
    end
  end

  assign tick        = tick_q;
  assign out_clk     = out_clk_q;
  assign active_freq = active_freq_q;
  assign clamped     = clamped_q;

endmodule
